fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/rr_pick.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO-controller definitions: arbiter state encoding and the
// round-robin search helper.
package fifo_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // First set bit of req[n-1:0], searching upward from (last+1) mod n with wrap.
  // Returns last when nothing is set.
  function automatic logic [2:0] rr_first(input logic [MAX_REQ-1:0] req,
                                          input int unsigned last,
                                          input int unsigned n);
    logic        found;
    int unsigned idx;
    rr_first = last[2:0];
    found    = 1'b0;
    for (int unsigned i = 1; i <= n; i++) begin
      idx = (last + i) % n;
      if (!found && req[idx]) begin
        found    = 1'b1;
        rr_first = idx[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next owner after `last` among set req bits.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] pick,
  output logic                    any
);

  localparam int unsigned OW = $clog2(NREQ);

  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]         pick_full;

  always_comb begin
    req_pad   = MAX_REQ'(req);
    pick_full = rr_first(req_pad, 32'(last), NREQ);
    pick      = pick_full[OW-1:0];
    any       = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a tenure of up to
// BURST words into an external FIFO, with one arbitration cycle per tenure.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned BURST  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_wdata,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(BURST + 1);

  arb_state_e      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   pick;
  logic            any_req;
  logic            xfer;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req  (req),
    .last (owner_q),
    .pick (pick),
    .any  (any_req)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    xfer    = (state_q == ST_BUSY) && req[owner_q] && !fifo_full;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Dropped request ends the tenure; a full FIFO only stalls it.
        if (!req[owner_q]) begin
          state_d = ST_IDLE;
        end else if (!fifo_full) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == CW'(BURST)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt        = '0;
    fifo_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        gnt[i] = xfer;
        if (state_q == ST_BUSY) begin
          fifo_wdata = wdata[i*DWIDTH +: DWIDTH];
        end
      end
    end
    fifo_wr_en = xfer;
    busy       = (state_q == ST_BUSY);
    owner      = owner_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
